// File: rtl/fp32_mul_pipe.sv
// Pipelined binary32 multiplier: classify, mantissa product, normalize/round, exception pack.
// Four register ranks give a result three edges after the sampling edge.
module fp32_mul_pipe #(
  parameter int LATENCY = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [2:0]  r_mode,
  input  logic [31:0] fp_X,
  input  logic [31:0] fp_Y,
  output logic        out_valid,
  output logic [31:0] fp_Z,
  output logic        ovrf,
  output logic        udrf,
  output logic        NAN
);

  localparam logic [2:0] MODE_RNE = 3'd0;
  localparam logic [2:0] MODE_RTZ = 3'd1;
  localparam logic [2:0] MODE_RDN = 3'd2;
  localparam logic [2:0] MODE_RUP = 3'd3;
  localparam logic [2:0] MODE_RMM = 3'd4;

  logic [LATENCY-1:0] stage_valid_q, stage_valid_d;

  logic              sign1_q, sign1_d, nan1_q, nan1_d, inf1_q, inf1_d, zero1_q, zero1_d;
  logic [2:0]        mode1_q, mode1_d;
  logic signed [9:0] exp1_q, exp1_d;
  logic [23:0]       mx1_q, mx1_d, my1_q, my1_d;

  logic              sign2_q, sign2_d, nan2_q, nan2_d, inf2_q, inf2_d, zero2_q, zero2_d;
  logic [2:0]        mode2_q, mode2_d;
  logic signed [9:0] exp2_q, exp2_d;
  logic [47:0]       prod2_q, prod2_d;

  logic              sign3_q, sign3_d, nan3_q, nan3_d, inf3_q, inf3_d, zero3_q, zero3_d;
  logic [2:0]        mode3_q, mode3_d;
  logic signed [9:0] exp3_q, exp3_d;
  logic [22:0]       frac3_q, frac3_d;

  logic        out_valid_q, out_valid_d, ovrf_q, ovrf_d, udrf_q, udrf_d, nan_q, nan_d;
  logic [31:0] fp_z_q, fp_z_d;

  logic        zero_x, zero_y, inf_x, inf_y, nan_x, nan_y;
  logic [23:0] norm_mant;
  logic        guard, sticky, round_inc;
  logic signed [9:0] norm_exp;
  logic [24:0] round_mant;
  logic [31:0] inf_word, max_word;

  assign stage_valid_d = {stage_valid_q[LATENCY-2:0], in_valid};
  assign out_valid_d   = stage_valid_q[LATENCY-1];

  // Stage 1: unpack and classify; subnormal operands collapse into the zero class.
  always_comb begin
    zero_x = (fp_X[30:23] == 8'h00);
    zero_y = (fp_Y[30:23] == 8'h00);
    inf_x  = (fp_X[30:23] == 8'hFF) && (fp_X[22:0] == 23'd0);
    inf_y  = (fp_Y[30:23] == 8'hFF) && (fp_Y[22:0] == 23'd0);
    nan_x  = (fp_X[30:23] == 8'hFF) && (fp_X[22:0] != 23'd0);
    nan_y  = (fp_Y[30:23] == 8'hFF) && (fp_Y[22:0] != 23'd0);
    sign1_d = sign1_q;
    nan1_d  = nan1_q;
    inf1_d  = inf1_q;
    zero1_d = zero1_q;
    mode1_d = mode1_q;
    exp1_d  = exp1_q;
    mx1_d   = mx1_q;
    my1_d   = my1_q;
    if (in_valid) begin
      sign1_d = fp_X[31] ^ fp_Y[31];
      nan1_d  = nan_x | nan_y | (inf_x & zero_y) | (inf_y & zero_x);
      inf1_d  = inf_x | inf_y;
      zero1_d = zero_x | zero_y;
      mode1_d = (r_mode > MODE_RMM) ? MODE_RNE : r_mode;
      exp1_d  = $signed({2'b00, fp_X[30:23]}) + $signed({2'b00, fp_Y[30:23]}) - 10'sd127;
      mx1_d   = {1'b1, fp_X[22:0]};
      my1_d   = {1'b1, fp_Y[22:0]};
    end
  end

  always_comb begin
    sign2_d = sign2_q;
    nan2_d  = nan2_q;
    inf2_d  = inf2_q;
    zero2_d = zero2_q;
    mode2_d = mode2_q;
    exp2_d  = exp2_q;
    prod2_d = prod2_q;
    if (stage_valid_q[0]) begin
      sign2_d = sign1_q;
      nan2_d  = nan1_q;
      inf2_d  = inf1_q;
      zero2_d = zero1_q;
      mode2_d = mode1_q;
      exp2_d  = exp1_q;
      prod2_d = mx1_q * my1_q;
    end
  end

  // Stage 3: normalize to 1.x, round with guard/sticky, renormalize on carry-out to 2.0.
  always_comb begin
    if (prod2_q[47]) begin
      norm_mant = prod2_q[47:24];
      guard     = prod2_q[23];
      sticky    = |prod2_q[22:0];
      norm_exp  = exp2_q + 10'sd1;
    end else begin
      norm_mant = prod2_q[46:23];
      guard     = prod2_q[22];
      sticky    = |prod2_q[21:0];
      norm_exp  = exp2_q;
    end
    case (mode2_q)
      MODE_RTZ: round_inc = 1'b0;
      MODE_RDN: round_inc = (guard | sticky) & sign2_q;
      MODE_RUP: round_inc = (guard | sticky) & ~sign2_q;
      MODE_RMM: round_inc = guard;
      default:  round_inc = guard & (sticky | norm_mant[0]);
    endcase
    round_mant = {1'b0, norm_mant} + {24'd0, round_inc};
    sign3_d = sign3_q;
    nan3_d  = nan3_q;
    inf3_d  = inf3_q;
    zero3_d = zero3_q;
    mode3_d = mode3_q;
    exp3_d  = exp3_q;
    frac3_d = frac3_q;
    if (stage_valid_q[1]) begin
      sign3_d = sign2_q;
      nan3_d  = nan2_q;
      inf3_d  = inf2_q;
      zero3_d = zero2_q;
      mode3_d = mode2_q;
      exp3_d  = round_mant[24] ? norm_exp + 10'sd1 : norm_exp;
      frac3_d = round_mant[24] ? round_mant[23:1] : round_mant[22:0];
    end
  end

  // Output stage: special operands win over range exceptions; results hold across bubbles.
  always_comb begin
    inf_word = {sign3_q, 8'hFF, 23'd0};
    max_word = {sign3_q, 8'hFE, 23'h7FFFFF};
    fp_z_d = fp_z_q;
    ovrf_d = ovrf_q;
    udrf_d = udrf_q;
    nan_d  = nan_q;
    if (stage_valid_q[2]) begin
      ovrf_d = 1'b0;
      udrf_d = 1'b0;
      nan_d  = 1'b0;
      if (nan3_q) begin
        fp_z_d = 32'h7FC00000;
        nan_d  = 1'b1;
      end else if (inf3_q) begin
        fp_z_d = inf_word;
      end else if (zero3_q) begin
        fp_z_d = {sign3_q, 31'd0};
      end else if (exp3_q >= 10'sd255) begin
        ovrf_d = 1'b1;
        case (mode3_q)
          MODE_RTZ: fp_z_d = max_word;
          MODE_RDN: fp_z_d = sign3_q ? inf_word : max_word;
          MODE_RUP: fp_z_d = sign3_q ? max_word : inf_word;
          default:  fp_z_d = inf_word;
        endcase
      end else if (exp3_q <= 10'sd0) begin
        udrf_d = 1'b1;
        fp_z_d = {sign3_q, 31'd0};
      end else begin
        fp_z_d = {sign3_q, exp3_q[7:0], frac3_q};
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage_valid_q <= '0;
      sign1_q <= 1'b0; nan1_q <= 1'b0; inf1_q <= 1'b0; zero1_q <= 1'b0;
      mode1_q <= 3'd0; exp1_q <= 10'sd0; mx1_q <= 24'd0; my1_q <= 24'd0;
      sign2_q <= 1'b0; nan2_q <= 1'b0; inf2_q <= 1'b0; zero2_q <= 1'b0;
      mode2_q <= 3'd0; exp2_q <= 10'sd0; prod2_q <= 48'd0;
      sign3_q <= 1'b0; nan3_q <= 1'b0; inf3_q <= 1'b0; zero3_q <= 1'b0;
      mode3_q <= 3'd0; exp3_q <= 10'sd0; frac3_q <= 23'd0;
      out_valid_q <= 1'b0; ovrf_q <= 1'b0; udrf_q <= 1'b0; nan_q <= 1'b0;
      fp_z_q <= 32'd0;
    end else begin
      stage_valid_q <= stage_valid_d;
      sign1_q <= sign1_d; nan1_q <= nan1_d; inf1_q <= inf1_d; zero1_q <= zero1_d;
      mode1_q <= mode1_d; exp1_q <= exp1_d; mx1_q <= mx1_d; my1_q <= my1_d;
      sign2_q <= sign2_d; nan2_q <= nan2_d; inf2_q <= inf2_d; zero2_q <= zero2_d;
      mode2_q <= mode2_d; exp2_q <= exp2_d; prod2_q <= prod2_d;
      sign3_q <= sign3_d; nan3_q <= nan3_d; inf3_q <= inf3_d; zero3_q <= zero3_d;
      mode3_q <= mode3_d; exp3_q <= exp3_d; frac3_q <= frac3_d;
      out_valid_q <= out_valid_d; ovrf_q <= ovrf_d; udrf_q <= udrf_d; nan_q <= nan_d;
      fp_z_q <= fp_z_d;
    end
  end

  assign out_valid = out_valid_q;
  assign fp_Z      = fp_z_q;
  assign ovrf      = ovrf_q;
  assign udrf      = udrf_q;
  assign NAN       = nan_q;

endmodule

// File: tb/tb_fp32_mul_pipe.sv
// Directed bench for fp32_mul_pipe: latency, rounding modes, exceptions, pipelining, reset.
module tb_fp32_mul_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [2:0]  r_mode;
  logic [31:0] fp_X, fp_Y;
  logic        out_valid, ovrf, udrf, NAN;
  logic [31:0] fp_Z;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp32_mul_pipe #(.LATENCY(3)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .r_mode(r_mode),
    .fp_X(fp_X), .fp_Y(fp_Y), .out_valid(out_valid), .fp_Z(fp_Z),
    .ovrf(ovrf), .udrf(udrf), .NAN(NAN)
  );

  // Packed expectation: {out_valid, ovrf, udrf, NAN, fp_Z}.
  function automatic logic [35:0] res(input logic [31:0] z, input logic ov, input logic ud,
                                      input logic nan);
    return {1'b1, ov, ud, nan, z};
  endfunction

  task automatic checkOutput(input string tag, input logic [35:0] expected);
    logic [35:0] observed;
    observed = {out_valid, ovrf, udrf, NAN, fp_Z};
    checks++;
    assert (observed === expected) else begin
      errors++;
      $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      $error("[TB] check %s did not hold", tag);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] x, input logic [31:0] y, input logic [2:0] m);
    @(negedge clk);
    fp_X = x;
    fp_Y = y;
    r_mode = m;
    in_valid = 1'b1;
  endtask

  task automatic runSingle(input string tag, input logic [31:0] x, input logic [31:0] y,
                           input logic [2:0] m, input logic [35:0] expected);
    applyStimulus(x, y, m);
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 checkOutput(tag, expected);
  endtask

  initial begin
    reset = 1'b0;
    in_valid = 1'b0;
    r_mode = 3'd0;
    fp_X = 32'd0;
    fp_Y = 32'd0;
    repeat (3) @(posedge clk);
    #1 checkOutput("reset_state", 36'd0);
    @(negedge clk);
    reset = 1'b1;

    // Latency: nothing visible until the third edge after sampling.
    applyStimulus(32'h3FC00000, 32'h40000000, 3'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 checkOutput("lat_n1", 36'd0);
    @(posedge clk);
    #1 checkOutput("lat_n2", 36'd0);
    @(posedge clk);
    #1 checkOutput("lat_n3", res(32'h40400000, 1'b0, 1'b0, 1'b0));

    runSingle("ovf_rne",     32'h7F7FFFFF, 32'h40000000, 3'd0, res(32'h7F800000, 1'b1, 1'b0, 1'b0));
    runSingle("ovf_rtz",     32'h7F7FFFFF, 32'h40000000, 3'd1, res(32'h7F7FFFFF, 1'b1, 1'b0, 1'b0));
    runSingle("ovf_rup_neg", 32'hFF7FFFFF, 32'h40000000, 3'd3, res(32'hFF7FFFFF, 1'b1, 1'b0, 1'b0));
    runSingle("ovf_rdn_neg", 32'hFF7FFFFF, 32'h40000000, 3'd2, res(32'hFF800000, 1'b1, 1'b0, 1'b0));
    runSingle("ovf_rdn_pos", 32'h7F7FFFFF, 32'h40000000, 3'd2, res(32'h7F7FFFFF, 1'b1, 1'b0, 1'b0));
    runSingle("udf_pos",     32'h00800000, 32'h00800000, 3'd0, res(32'h00000000, 1'b0, 1'b1, 1'b0));
    runSingle("udf_neg",     32'h80800000, 32'h00800000, 3'd0, res(32'h80000000, 1'b0, 1'b1, 1'b0));
    runSingle("sub_input",   32'h00000001, 32'h3F800000, 3'd0, res(32'h00000000, 1'b0, 1'b0, 1'b0));
    runSingle("nan_inf_x0",  32'h7F800000, 32'h00000000, 3'd0, res(32'h7FC00000, 1'b0, 1'b0, 1'b1));
    runSingle("nan_input",   32'h7FC00001, 32'h3F800000, 3'd0, res(32'h7FC00000, 1'b0, 1'b0, 1'b1));
    runSingle("inf_neg",     32'hFF800000, 32'h40000000, 3'd0, res(32'hFF800000, 1'b0, 1'b0, 1'b0));
    runSingle("rnd_rne",     32'h3F800001, 32'h3F800001, 3'd0, res(32'h3F800002, 1'b0, 1'b0, 1'b0));
    runSingle("rnd_rtz",     32'h3F800001, 32'h3F800001, 3'd1, res(32'h3F800002, 1'b0, 1'b0, 1'b0));
    runSingle("rnd_rup",     32'h3F800001, 32'h3F800001, 3'd3, res(32'h3F800003, 1'b0, 1'b0, 1'b0));
    runSingle("rnd_rdn_neg", 32'hBF800001, 32'h3F800001, 3'd2, res(32'hBF800003, 1'b0, 1'b0, 1'b0));
    runSingle("rnd_rup_neg", 32'hBF800001, 32'h3F800001, 3'd3, res(32'hBF800002, 1'b0, 1'b0, 1'b0));
    runSingle("rnd_rmm",     32'h3F800001, 32'h3F800001, 3'd4, res(32'h3F800002, 1'b0, 1'b0, 1'b0));
    runSingle("rnd_mode5",   32'h3F800001, 32'h3F800001, 3'd5, res(32'h3F800002, 1'b0, 1'b0, 1'b0));

    // Back-to-back operations, each with its own rounding mode.
    applyStimulus(32'h3F800001, 32'h3F800001, 3'd3);
    @(posedge clk);
    #1 begin fp_X = 32'h3F800001; fp_Y = 32'h3F800001; r_mode = 3'd0; end
    @(posedge clk);
    #1 begin fp_X = 32'h7F7FFFFF; fp_Y = 32'h40000000; r_mode = 3'd0; end
    @(posedge clk);
    #1 begin fp_X = 32'h7F7FFFFF; fp_Y = 32'h40000000; r_mode = 3'd1; end
    @(posedge clk);
    #1 in_valid = 1'b0;
    checkOutput("pipe_op1", res(32'h3F800003, 1'b0, 1'b0, 1'b0));
    @(posedge clk);
    #1 checkOutput("pipe_op2", res(32'h3F800002, 1'b0, 1'b0, 1'b0));
    @(posedge clk);
    #1 checkOutput("pipe_op3", res(32'h7F800000, 1'b1, 1'b0, 1'b0));
    @(posedge clk);
    #1 checkOutput("pipe_op4", res(32'h7F7FFFFF, 1'b1, 1'b0, 1'b0));
    @(posedge clk);
    #1 checkOutput("pipe_bubble_hold", {1'b0, 1'b1, 1'b0, 1'b0, 32'h7F7FFFFF});

    // Reset mid-stream after two issued operations.
    applyStimulus(32'h3FC00000, 32'h40000000, 3'd0);
    @(posedge clk);
    #1 begin fp_X = 32'h3F800001; fp_Y = 32'h3F800001; r_mode = 3'd3; end
    @(posedge clk);
    #1 in_valid = 1'b0;
    #2 reset = 1'b0;
    #1 checkOutput("rst_async_clear", 36'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 checkOutput($sformatf("rst_no_valid_%0d", i), 36'd0);
    end
    runSingle("post_reset_op", 32'h3FC00000, 32'h40000000, 3'd0, res(32'h40400000, 1'b0, 1'b0, 1'b0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
